// File: rtl/aia_pkg.sv
// Shared types and constants for the AIA interrupt claim controller.
// File indices: 0 = M, 1 = S, VS_BASE.. = guest (VS) files.
package aia_pkg;

    localparam int M_FILE  = 0;
    localparam int S_FILE  = 1;
    localparam int VS_BASE = 2;

    // Widest file index and identity an offer can carry.
    // Instances slice these down to their real widths.
    localparam int OFFER_FILE_W = 8;
    localparam int OFFER_ID_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        CLAIM  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    typedef struct packed {
        logic [OFFER_FILE_W-1:0] file;
        logic [OFFER_ID_W-1:0]   id;
    } offer_t;

    // Width of the guest-select field.
    // At least one bit, even when there are no guest files.
    function automatic int vgein_w(input int nr_vs);
        int w;
        w = $clog2(nr_vs + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/aia_file_prio_sel.sv
// Combinational deliverable detection and M > S > selected-VS priority pick.
module aia_file_prio_sel
    import aia_pkg::*;
#(
    parameter int NrVSIntpFiles = 0,
    parameter int NrIntpFiles   = 2 + NrVSIntpFiles,
    parameter int NrSourcesW    = 5,
    parameter int VgeinW        = 1
) (
    input  logic [NrIntpFiles*NrSourcesW-1:0] pend_id,
    input  logic [NrIntpFiles-1:0]            deliv_en,
    input  logic [VgeinW-1:0]                 vgein,
    output logic [NrIntpFiles-1:0]            deliv,
    output logic                              sel_valid,
    output offer_t                            sel
);

    // A guest file counts only when vgein selects it.
    // vgein 0 or out of range therefore matches no file.
    always_comb begin
        deliv = '0;
        for (int f = 0; f < NrIntpFiles; f++) begin
            if (pend_id[f*NrSourcesW +: NrSourcesW] != '0 && deliv_en[f]) begin
                if (f < VS_BASE) begin
                    deliv[f] = 1'b1;
                end else if (int'(vgein) == f - VS_BASE + 1) begin
                    deliv[f] = 1'b1;
                end
            end
        end
    end

    // Scan from the lowest priority upwards.
    // The last hit is the lowest index, which is the highest privilege.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        for (int f = NrIntpFiles - 1; f >= 0; f--) begin
            if (deliv[f]) begin
                sel_valid = 1'b1;
                sel.file  = OFFER_FILE_W'(f);
                sel.id    = OFFER_ID_W'(pend_id[f*NrSourcesW +: NrSourcesW]);
            end
        end
    end

endmodule

// File: rtl/aia_intp_claim_ctrl.sv
// Offers the winning interrupt file/identity to the hart and pulses the claim back.
// valid/ready: an offer is taken in any cycle where irq_valid_o & irq_ready_i; valid may drop without a take.
module aia_intp_claim_ctrl
    import aia_pkg::*;
#(
    parameter int NrVSIntpFiles = 0,
    parameter int NrIntpFiles   = 2 + NrVSIntpFiles,
    parameter int NrSourcesW    = 5,
    localparam int VgeinW       = vgein_w(NrVSIntpFiles),
    localparam int FileW        = $clog2(NrIntpFiles)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrIntpFiles*NrSourcesW-1:0] pend_id_i,
    input  logic [NrIntpFiles-1:0]            deliv_en_i,
    input  logic [VgeinW-1:0]                 vgein_i,
    output logic                              irq_valid_o,
    output logic [FileW-1:0]                  irq_file_o,
    output logic [NrSourcesW-1:0]             irq_id_o,
    input  logic                              irq_ready_i,
    output logic [NrIntpFiles-1:0]            claim_o,
    output logic [NrSourcesW-1:0]             claim_id_o,
    output logic                              meip_o,
    output logic                              seip_o,
    output logic                              vseip_o,
    output state_t                            state_o
);

    logic [NrIntpFiles-1:0] deliv;
    logic                   sel_valid;
    offer_t                 sel;

    aia_file_prio_sel #(
        .NrVSIntpFiles (NrVSIntpFiles),
        .NrIntpFiles   (NrIntpFiles),
        .NrSourcesW    (NrSourcesW),
        .VgeinW        (VgeinW)
    ) u_prio_sel (
        .pend_id   (pend_id_i),
        .deliv_en  (deliv_en_i),
        .vgein     (vgein_i),
        .deliv     (deliv),
        .sel_valid (sel_valid),
        .sel       (sel)
    );

    state_t                state;
    logic                  vs_any;
    logic [NrSourcesW-1:0] cur_pend;
    logic                  cur_deliv;
    logic                  preempt;
    logic                  unused_sel_hi;

    assign state_o       = state;
    assign unused_sel_hi = ^{sel.file[OFFER_FILE_W-1:FileW], sel.id[OFFER_ID_W-1:NrSourcesW]};

    always_comb begin
        vs_any = 1'b0;
        for (int f = VS_BASE; f < NrIntpFiles; f++) begin
            vs_any = vs_any | deliv[f];
        end
    end

    // Live view of the file currently on offer.
    always_comb begin
        cur_pend  = pend_id_i[int'(irq_file_o)*NrSourcesW +: NrSourcesW];
        cur_deliv = deliv[irq_file_o];
        preempt   = sel_valid && (sel.file < OFFER_FILE_W'(irq_file_o));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            irq_valid_o <= 1'b0;
            irq_file_o  <= '0;
            irq_id_o    <= '0;
            claim_o     <= '0;
            claim_id_o  <= '0;
            meip_o      <= 1'b0;
            seip_o      <= 1'b0;
            vseip_o     <= 1'b0;
        end else begin
            meip_o  <= deliv[M_FILE];
            seip_o  <= deliv[S_FILE];
            vseip_o <= vs_any;
            case (state)
                IDLE: begin
                    claim_o <= '0;
                    if (sel_valid) begin
                        irq_valid_o <= 1'b1;
                        irq_file_o  <= sel.file[FileW-1:0];
                        irq_id_o    <= sel.id[NrSourcesW-1:0];
                        state       <= OFFER;
                    end
                end
                OFFER: begin
                    // A take beats any same-cycle withdraw, preempt or refresh.
                    if (irq_ready_i) begin
                        irq_valid_o <= 1'b0;
                        claim_o     <= NrIntpFiles'(1) << irq_file_o;
                        claim_id_o  <= irq_id_o;
                        state       <= CLAIM;
                    end else if (preempt) begin
                        irq_file_o <= sel.file[FileW-1:0];
                        irq_id_o   <= sel.id[NrSourcesW-1:0];
                    end else if (!cur_deliv) begin
                        irq_valid_o <= 1'b0;
                        state       <= IDLE;
                    end else if (cur_pend != irq_id_o) begin
                        irq_id_o <= cur_pend;
                    end
                end
                CLAIM: begin
                    claim_o <= '0;
                    state   <= SETTLE;
                end
                SETTLE: begin
                    // Give the claimed file one cycle to update its pend_id.
                    state <= IDLE;
                end
                default: begin
                    irq_valid_o <= 1'b0;
                    claim_o     <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aia_intp_claim_ctrl.sv
// Self-checking bench for aia_intp_claim_ctrl with two guest files.
module tb_aia_intp_claim_ctrl;
    import aia_pkg::*;

    localparam int NV = 2;
    localparam int NF = 2 + NV;
    localparam int SW = 5;
    localparam int VW = 2;
    localparam int FW = 2;
    localparam int CW = NF + SW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NF*SW-1:0]  pend_id;
    logic [NF-1:0]     deliv_en;
    logic [VW-1:0]     vgein;
    logic              irq_ready;
    logic              irq_valid;
    logic [FW-1:0]     irq_file;
    logic [SW-1:0]     irq_id;
    logic [NF-1:0]     claim;
    logic [SW-1:0]     claim_id;
    logic              meip, seip, vseip;
    state_t            state;

    aia_intp_claim_ctrl #(
        .NrVSIntpFiles (NV),
        .NrSourcesW    (SW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pend_id_i   (pend_id),
        .deliv_en_i  (deliv_en),
        .vgein_i     (vgein),
        .irq_valid_o (irq_valid),
        .irq_file_o  (irq_file),
        .irq_id_o    (irq_id),
        .irq_ready_i (irq_ready),
        .claim_o     (claim),
        .claim_id_o  (claim_id),
        .meip_o      (meip),
        .seip_o      (seip),
        .vseip_o     (vseip),
        .state_o     (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pend(input int f, input int id);
        pend_id[f*SW +: SW] = SW'(id);
    endtask

    task automatic check_offer(input string tag, input int f, input int id);
        check_eq({tag, "_valid"}, 32'(irq_valid), 1);
        check_eq({tag, "_file"}, 32'(irq_file), 32'(f));
        check_eq({tag, "_id"}, 32'(irq_id), 32'(id));
    endtask

    task automatic take(input int f, input int id);
        irq_ready = 1'b1;
        exp_q.push_back({NF'(1) << f, SW'(id)});
        tick();
        irq_ready = 1'b0;
        check_eq("claim_state", 32'(state), 32'(CLAIM));
        check_eq("claim_valid_low", 32'(irq_valid), 0);
    endtask

    // scoreboard: every claim pulse must match the head of exp_q
    always @(negedge clk) begin
        if (!rst && claim != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_claim", 32'(claim), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("claim_vec", 32'(claim), 32'(mon_e[CW-1:SW]));
                check_eq("claim_id", 32'(claim_id), 32'(mon_e[SW-1:0]));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        pend_id   = '0;
        deliv_en  = '0;
        vgein     = '0;
        irq_ready = 1'b0;
        #12;
        check_eq("rst_valid", 32'(irq_valid), 0);
        check_eq("rst_file", 32'(irq_file), 0);
        check_eq("rst_id", 32'(irq_id), 0);
        check_eq("rst_claim", 32'(claim), 0);
        check_eq("rst_claim_id", 32'(claim_id), 0);
        check_eq("rst_eip", 32'({meip, seip, vseip}), 0);
        check_eq("rst_state", 32'(state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // S offer, take, three dead cycles, re-offer at h+4
        deliv_en = 4'b0011;
        set_pend(1, 7);
        tick();
        check_offer("s_offer", 1, 7);
        check_eq("s_seip", 32'(seip), 1);
        check_eq("s_meip", 32'(meip), 0);
        take(1, 7);
        tick();
        check_eq("settle_valid", 32'(irq_valid), 0);
        check_eq("settle_state", 32'(state), 32'(SETTLE));
        tick();
        check_eq("idle_valid", 32'(irq_valid), 0);
        tick();
        check_offer("reoffer", 1, 7);

        // M preempts S while ready is low
        set_pend(0, 3);
        tick();
        check_offer("preempt", 0, 3);
        check_eq("preempt_meip", 32'(meip), 1);
        take(0, 3);
        pend_id = '0;
        repeat (3) tick();
        check_eq("after_m_idle", 32'(state), 32'(IDLE));

        // refresh then withdraw on the same file
        set_pend(1, 9);
        tick();
        check_offer("refresh_a", 1, 9);
        set_pend(1, 4);
        tick();
        check_offer("refresh_b", 1, 4);
        set_pend(1, 0);
        tick();
        check_eq("withdraw_valid", 32'(irq_valid), 0);
        check_eq("withdraw_state", 32'(state), 32'(IDLE));

        // guest file selected by vgein, then deselected
        deliv_en = 4'b1111;
        vgein    = 2'd2;
        set_pend(3, 12);
        tick();
        check_offer("vs_offer", 3, 12);
        check_eq("vs_vseip", 32'(vseip), 1);
        vgein = 2'd1;
        tick();
        check_eq("vs_move_valid", 32'(irq_valid), 0);
        check_eq("vs_move_state", 32'(state), 32'(IDLE));
        check_eq("vs_move_vseip", 32'(vseip), 0);
        vgein = 2'd3;
        repeat (2) tick();
        check_eq("vs_oor_valid", 32'(irq_valid), 0);
        set_pend(3, 0);
        vgein = 2'd0;

        // handshake wins over a same-cycle withdraw
        set_pend(1, 5);
        tick();
        check_offer("hs_offer", 1, 5);
        set_pend(1, 0);
        take(1, 5);
        repeat (3) tick();
        check_eq("hs_after_valid", 32'(irq_valid), 0);

        // ready outside OFFER is ignored
        irq_ready = 1'b1;
        repeat (2) tick();
        irq_ready = 1'b0;
        check_eq("ready_idle_state", 32'(state), 32'(IDLE));

        // delivery disabled on M
        deliv_en = 4'b0010;
        set_pend(0, 5);
        repeat (2) tick();
        check_eq("dis_valid", 32'(irq_valid), 0);
        check_eq("dis_meip", 32'(meip), 0);
        deliv_en = 4'b0011;
        tick();
        check_offer("en_offer", 0, 5);
        check_eq("en_meip", 32'(meip), 1);

        // reset during CLAIM kills the pulse; its claim is not expected
        irq_ready = 1'b1;
        tick();
        rst       = 1'b1;
        irq_ready = 1'b0;
        #1;
        check_eq("rst_claim_vec", 32'(claim), 0);
        check_eq("rst_claim_valid", 32'(irq_valid), 0);
        check_eq("rst_claim_state", 32'(state), 32'(IDLE));
        tick();
        rst = 1'b0;
        tick();
        check_offer("post_rst", 0, 5);
        take(0, 5);
        set_pend(0, 0);
        repeat (3) tick();

        // random M/S single offers
        for (int i = 0; i < 4; i++) begin
            int f, id;
            f  = $urandom_range(0, 1);
            id = $urandom_range(1, 31);
            set_pend(f, id);
            tick();
            check_offer("rand_offer", f, id);
            take(f, id);
            set_pend(f, 0);
            repeat (3) tick();
        end

        repeat (3) tick();
        check_eq("exp_q_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
